// File: rtl/demx_slot_sched_pkg.sv
// Shared types and constants for the demux slot scheduler.
package demx_slot_sched_pkg;

    localparam int NUM_LANES = 8;
    localparam int SEL_W     = 3;

    // Scheduler state encoding; exported on the interface for observation.
    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

endpackage

// File: rtl/demx_slot_sched_if.sv
// Interface bundling the scheduler's control inputs and lane outputs.
//
// Handshake: there is no valid/ready pair. en and mask are levels the
// scheduler samples only in IDLE and at slot boundaries. hold and k are
// honoured every cycle. slot_start and frame_done are single-cycle
// strobes aligned with the first cycle of a slot.
interface demx_slot_sched_if;
    import demx_slot_sched_pkg::*;

    logic                 en;
    logic [NUM_LANES-1:0] mask;
    logic                 hold;
    logic                 k;
    logic [SEL_W-1:0]     sel;
    logic [NUM_LANES-1:0] y;
    logic                 busy;
    logic                 slot_start;
    logic                 frame_done;
    state_t               dbg_state;

    modport master (
        output en, mask, hold, k,
        input  sel, y, busy, slot_start, frame_done, dbg_state
    );

    modport slave (
        input  en, mask, hold, k,
        output sel, y, busy, slot_start, frame_done, dbg_state
    );
endinterface

// File: rtl/demx1_8.sv
// Combinational 1:8 demultiplexer with enable.
module demx1_8 (
    input  logic       i_en,
    input  logic [2:0] i_sel,
    output logic [7:0] o_y
);
    // Drive only the selected lane; all others stay low.
    always_comb begin
        o_y = 8'd0;
        o_y[i_sel] = i_en;
    end
endmodule

// File: rtl/demx_slot_sched_rr_next8.sv
// Round-robin search over 8 lanes: first set mask bit at/after base.
module rr_next8 (
    input  logic [7:0] i_mask,
    input  logic [2:0] i_base,
    input  logic       i_incl,
    output logic [2:0] o_nxt,
    output logic       o_found
);
    logic [2:0] w_off;
    logic [2:0] w_idx;

    // Scan from the farthest offset down so the nearest hit wins.
    always_comb begin
        o_nxt   = i_base;
        o_found = |i_mask;
        w_off   = 3'd0;
        w_idx   = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            // Excluding base shifts offsets by one; offset 8 wraps to base itself.
            w_off = i_incl ? 3'(i) : 3'(i + 1);
            w_idx = i_base + w_off;
            if (i_mask[w_idx]) begin
                o_nxt = w_idx;
            end
        end
    end
endmodule

// File: rtl/demx_slot_sched.sv
// Time-division scheduler driving the select of the 1:8 demux.
module demx_slot_sched
    import demx_slot_sched_pkg::*;
#(
    parameter int DWELL = 4,
    parameter int CW    = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    demx_slot_sched_if.slave   bus
);
    localparam logic [CW-1:0] DWELL_M1 = CW'(DWELL - 1);

    state_t           r_state;
    logic [SEL_W-1:0] r_sel;
    logic [SEL_W-1:0] r_rr_ptr;
    logic [CW-1:0]    r_cnt;
    logic             r_busy;
    logic             r_slot_start;
    logic             r_frame_done;

    logic [SEL_W-1:0] w_base;
    logic             w_incl;
    logic [SEL_W-1:0] w_nxt;
    logic             w_found;
    logic             w_go;

    // IDLE resumes from the saved pointer inclusively; ACTIVE looks strictly past sel.
    assign w_base = (r_state == ST_IDLE) ? r_rr_ptr : r_sel;
    assign w_incl = (r_state == ST_IDLE);
    assign w_go   = bus.en & w_found;

    rr_next8 u_rr (
        .i_mask  (bus.mask),
        .i_base  (w_base),
        .i_incl  (w_incl),
        .o_nxt   (w_nxt),
        .o_found (w_found)
    );

    demx1_8 u_dmx (
        .i_en  (bus.k & r_busy),
        .i_sel (r_sel),
        .o_y   (bus.y)
    );

    // Slot FSM: start, dwell countdown with hold, boundary advance or stop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_sel        <= '0;
            r_rr_ptr     <= '0;
            r_cnt        <= '0;
            r_busy       <= 1'b0;
            r_slot_start <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_frame_done <= 1'b0;
                    if (w_go) begin
                        r_state      <= ST_ACTIVE;
                        r_sel        <= w_nxt;
                        r_cnt        <= DWELL_M1;
                        r_busy       <= 1'b1;
                        r_slot_start <= 1'b1;
                    end else begin
                        r_slot_start <= 1'b0;
                    end
                end
                ST_ACTIVE: begin
                    if (bus.hold) begin
                        // Hold freezes the countdown and defers any boundary.
                        r_slot_start <= 1'b0;
                        r_frame_done <= 1'b0;
                    end else if (r_cnt != '0) begin
                        r_cnt        <= r_cnt - CW'(1);
                        r_slot_start <= 1'b0;
                        r_frame_done <= 1'b0;
                    end else if (w_go) begin
                        r_sel        <= w_nxt;
                        r_cnt        <= DWELL_M1;
                        r_slot_start <= 1'b1;
                        r_frame_done <= (w_nxt <= r_sel);
                    end else begin
                        r_state      <= ST_IDLE;
                        r_rr_ptr     <= r_sel + 3'd1;
                        r_busy       <= 1'b0;
                        r_slot_start <= 1'b0;
                        r_frame_done <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign bus.sel        = r_sel;
    assign bus.busy       = r_busy;
    assign bus.slot_start = r_slot_start;
    assign bus.frame_done = r_frame_done;
    assign bus.dbg_state  = r_state;
endmodule

// File: tb/tb_demx_slot_sched.sv
// Bench for demx_slot_sched: vector table, directed corner sequences and
// randomized traffic checked against a slot-level reference model.
module tb_demx_slot_sched;
    import demx_slot_sched_pkg::*;

    localparam int DWELL = 4;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    demx_slot_sched_if bus_if ();

    demx_slot_sched #(.DWELL(DWELL), .CW(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if.slave)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Tracks the slot as "cycles still to serve"; a held cycle serves nothing.
    bit m_active;
    int m_lane;
    int m_ptr;
    int m_left;
    bit m_start;
    bit m_wrap;

    function automatic int pick(input logic [7:0] m, input int base, input bit incl);
        int first;
        int idx;
        first = incl ? 0 : 1;
        for (int off = first; off < first + 8; off++) begin
            idx = (base + off) % 8;
            if (m[idx]) return idx;
        end
        return -1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active = 0; m_lane = 0; m_ptr = 0; m_left = 0; m_start = 0; m_wrap = 0;
        end else if (!m_active) begin
            m_wrap = 0;
            if (bus_if.en && bus_if.mask != 0) begin
                m_active = 1;
                m_lane   = pick(bus_if.mask, m_ptr, 1);
                m_left   = DWELL;
                m_start  = 1;
            end else begin
                m_start = 0;
            end
        end else if (bus_if.hold) begin
            m_start = 0; m_wrap = 0;
        end else begin
            m_left = m_left - 1;
            if (m_left > 0) begin
                m_start = 0; m_wrap = 0;
            end else if (bus_if.en && bus_if.mask != 0) begin
                int nl;
                nl      = pick(bus_if.mask, m_lane, 0);
                m_wrap  = (nl <= m_lane);
                m_lane  = nl;
                m_left  = DWELL;
                m_start = 1;
            end else begin
                m_active = 0;
                m_ptr    = (m_lane + 1) % 8;
                m_start  = 0;
                m_wrap   = 0;
            end
        end
    end

    // ---------------- scoreboard helpers ----------------
    logic [7:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic chk_model(input string tag);
        logic [7:0] ey;
        ey = 8'd0;
        if (m_active && bus_if.k) ey[m_lane] = 1'b1;
        chk({tag, "_sel"},  32'(bus_if.sel),        32'(m_lane));
        chk({tag, "_busy"}, 32'(bus_if.busy),       32'(m_active));
        chk({tag, "_ss"},   32'(bus_if.slot_start), 32'(m_start));
        chk({tag, "_fd"},   32'(bus_if.frame_done), 32'(m_wrap));
        chk({tag, "_y"},    32'(bus_if.y),          32'(ey));
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input logic e, input logic [7:0] m, input logic h, input logic kk);
        bus_if.en   = e;
        bus_if.mask = m;
        bus_if.hold = h;
        bus_if.k    = kk;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_sel",  32'(bus_if.sel),        32'd0);
        chk("rst_busy", 32'(bus_if.busy),       32'd0);
        chk("rst_ss",   32'(bus_if.slot_start), 32'd0);
        chk("rst_fd",   32'(bus_if.frame_done), 32'd0);
        chk("rst_y",    32'(bus_if.y),          32'd0);
        #2 rst_n = 1'b1;
        tick();
    endtask

    // Run with mask m until the given lane is selected (optionally at slot start).
    task automatic run_until_lane(input logic [7:0] m, input logic [2:0] lane,
                                  input bit need_ss, input string tag);
        bit ok;
        ok = 0;
        for (int i = 0; i < 60 && !ok; i++) begin
            drive(1'b1, m, 1'b0, 1'($urandom));
            tick();
            chk_model(tag);
            if (bus_if.sel == lane && bus_if.busy && (!need_ss || bus_if.slot_start)) ok = 1;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: lane %0d never reached", tag, lane);
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic       en;
        logic [7:0] mask;
        logic       hold;
        logic       k;
        logic [2:0] sel;
        logic       busy;
        logic       ss;
        logic       fd;
        logic [7:0] y;
    } vec_t;

    vec_t tbl[13];

    function automatic vec_t mk(input logic kk, input logic [2:0] s, input logic ss,
                                input logic fd, input logic [7:0] y);
        vec_t v;
        v.en = 1'b1; v.mask = 8'b1010_0100; v.hold = 1'b0; v.k = kk;
        v.sel = s; v.busy = 1'b1; v.ss = ss; v.fd = fd; v.y = y;
        return v;
    endfunction

    // ---------------- test sequence ----------------
    initial begin
        int n;
        logic kk;
        logic [7:0] sel_v;
        checks = 0;
        errors = 0;
        rst_n  = 1'b1;
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        #3;

        // Skipping: lanes 2,5,7 then wrap to 2.
        tbl[0]  = mk(1'b1, 3'd2, 1'b1, 1'b0, 8'h04);
        tbl[1]  = mk(1'b0, 3'd2, 1'b0, 1'b0, 8'h00);
        tbl[2]  = mk(1'b1, 3'd2, 1'b0, 1'b0, 8'h04);
        tbl[3]  = mk(1'b1, 3'd2, 1'b0, 1'b0, 8'h04);
        tbl[4]  = mk(1'b1, 3'd5, 1'b1, 1'b0, 8'h20);
        tbl[5]  = mk(1'b0, 3'd5, 1'b0, 1'b0, 8'h00);
        tbl[6]  = mk(1'b1, 3'd5, 1'b0, 1'b0, 8'h20);
        tbl[7]  = mk(1'b0, 3'd5, 1'b0, 1'b0, 8'h00);
        tbl[8]  = mk(1'b1, 3'd7, 1'b1, 1'b0, 8'h80);
        tbl[9]  = mk(1'b1, 3'd7, 1'b0, 1'b0, 8'h80);
        tbl[10] = mk(1'b0, 3'd7, 1'b0, 1'b0, 8'h00);
        tbl[11] = mk(1'b1, 3'd7, 1'b0, 1'b0, 8'h80);
        tbl[12] = mk(1'b1, 3'd2, 1'b1, 1'b1, 8'h04);

        apply_reset();
        for (int i = 0; i < 13; i++) begin
            drive(tbl[i].en, tbl[i].mask, tbl[i].hold, tbl[i].k);
            tick();
            chk("tbl_sel",  32'(bus_if.sel),        32'(tbl[i].sel));
            chk("tbl_busy", 32'(bus_if.busy),       32'(tbl[i].busy));
            chk("tbl_ss",   32'(bus_if.slot_start), 32'(tbl[i].ss));
            chk("tbl_fd",   32'(bus_if.frame_done), 32'(tbl[i].fd));
            chk("tbl_y",    32'(bus_if.y),          32'(tbl[i].y));
            chk_model("tbl_model");
        end

        // Basic rotation over all lanes, expected starts queued up front.
        apply_reset();
        for (int i = 0; i < 9; i++) begin
            sel_v = 8'(i % 8);
            exp_q.push_back(sel_v);
        end
        for (int c = 1; c <= 36; c++) begin
            drive(1'b1, 8'hFF, 1'b0, 1'b1);
            tick();
            chk("rot_sel", 32'(bus_if.sel), 32'(((c - 1) / 4) % 8));
            chk("rot_y",   32'(bus_if.y),   32'(1 << (((c - 1) / 4) % 8)));
            chk("rot_ss",  32'(bus_if.slot_start), 32'(((c - 1) % 4) == 0));
            chk("rot_fd",  32'(bus_if.frame_done),
                32'((((c - 1) % 4) == 0) && c > 1 && (((c - 1) / 4) % 8) == 0));
            chk_model("rot_model");
            if (bus_if.slot_start) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rot_extra_start: got start on lane %0d, expected none", bus_if.sel);
                end else begin
                    sel_v = exp_q.pop_front();
                    chk("rot_q_sel", 32'(bus_if.sel), 32'(sel_v));
                end
            end
        end
        chk("rot_q_left", 32'(exp_q.size()), 32'd0);
        exp_q.delete();

        // Single lane: reselects itself with a wrap every slot.
        apply_reset();
        for (int c = 1; c <= 16; c++) begin
            drive(1'b1, 8'h08, 1'b0, 1'($urandom));
            tick();
            chk("one_sel", 32'(bus_if.sel), 32'd3);
            chk("one_ss",  32'(bus_if.slot_start), 32'(((c - 1) % 4) == 0));
            chk("one_fd",  32'(bus_if.frame_done), 32'((((c - 1) % 4) == 0) && c > 1));
            chk_model("one_model");
        end

        // Hold for 3 cycles on lane 1 stretches its slot to DWELL+3.
        apply_reset();
        run_until_lane(8'hFF, 3'd1, 1'b1, "hold_seek");
        n = 1;
        for (int i = 0; i < 3; i++) begin
            kk = 1'($urandom);
            drive(1'b1, 8'hFF, 1'b1, kk);
            tick();
            chk_model("hold_model");
            chk("hold_y1", 32'(bus_if.y[1]), 32'(kk));
            if (bus_if.sel == 3'd1) n++;
        end
        for (int i = 0; i < 20; i++) begin
            kk = 1'($urandom);
            drive(1'b1, 8'hFF, 1'b0, kk);
            tick();
            chk_model("hold_model");
            if (bus_if.sel != 3'd1) break;
            chk("hold_y1", 32'(bus_if.y[1]), 32'(kk));
            n++;
        end
        chk("hold_len", 32'(n), 32'(DWELL + 3));

        // Graceful stop on lane 4, then resume at lane 5 without wrap.
        apply_reset();
        run_until_lane(8'hFF, 3'd4, 1'b1, "stop_seek");
        n = 1;
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 8'hFF, 1'b0, 1'b1);
            tick();
            chk_model("stop_model");
            if (!(bus_if.busy && bus_if.sel == 3'd4)) break;
            n++;
        end
        chk("stop_len",  32'(n), 32'(DWELL));
        chk("stop_busy", 32'(bus_if.busy), 32'd0);
        chk("stop_y",    32'(bus_if.y), 32'd0);
        drive(1'b1, 8'hFF, 1'b0, 1'b1);
        tick();
        chk("resume_sel", 32'(bus_if.sel), 32'd5);
        chk("resume_ss",  32'(bus_if.slot_start), 32'd1);
        chk("resume_fd",  32'(bus_if.frame_done), 32'd0);
        chk_model("resume_model");

        // Asynchronous reset between edges while on lane 6.
        apply_reset();
        run_until_lane(8'hFF, 3'd6, 1'b0, "arst_seek");
        #2 rst_n = 1'b0;
        #1;
        chk("arst_sel",  32'(bus_if.sel),  32'd0);
        chk("arst_busy", 32'(bus_if.busy), 32'd0);
        chk("arst_y",    32'(bus_if.y),    32'd0);
        #1 rst_n = 1'b1;
        drive(1'b1, 8'hFF, 1'b0, 1'b1);
        tick();
        chk("arst_restart_sel", 32'(bus_if.sel), 32'd0);
        chk("arst_restart_ss",  32'(bus_if.slot_start), 32'd1);
        chk_model("arst_model");

        // Randomized traffic against the model.
        apply_reset();
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 9) != 0),
                  ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom),
                  1'($urandom_range(0, 5) == 0),
                  1'($urandom));
            tick();
            chk_model("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Absolute guard so the run always ends.
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end
endmodule

// File: doc/demx_slot_sched.md
Name: demx_slot_sched

Overview:
- Time-division scheduler that sequences the 3-bit select of the 1:8 demultiplexer (demx1_8).
- It routes serial bit input k to one of eight output lanes at a time. Each enabled lane gets a dwell slot of DWELL clock cycles.
- Lanes are served round-robin, and lanes disabled in mask are skipped.
- Sits between the lane-configuration registers and the existing combinational demux; owns sel, slot framing and frame-completion signalling.

Parameters:
- DWELL, 4, cycles per slot; legal range 1..255.
- CW, 8, width of the dwell down-counter; must satisfy 2^CW > DWELL.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous, active-low reset.
- en  input  1  run request; sampled only at slot boundaries and in IDLE.
- mask  input  8  lane enable, bit i = lane i; sampled only at slot boundaries and in IDLE.
- hold  input  1  freezes the dwell counter; routing continues.
- k  input  1  serial data bit to distribute.
- sel  output  3  current lane index (registered).
- y  output  8  demux outputs: y[sel]=k while ACTIVE, all other bits 0; all 0 in IDLE.
- busy  output  1  high while ACTIVE (registered).
- slot_start  output  1  one-cycle pulse in the first cycle of every slot.
- frame_done  output  1  one-cycle pulse in the first cycle of a slot whose lane index is less than or equal to the previous slot's lane (round-robin wrap).

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, sel=0, rr_ptr=0, cnt=0, busy=0, slot_start=0, frame_done=0, y=0.
- States: IDLE, ACTIVE.
- IDLE:
  - If en=1 and mask!=0 at a clock edge, choose the first enabled lane at or after rr_ptr, searching upward with wrap 7->0.
  - Load sel=that lane and cnt=DWELL-1; go to ACTIVE.
  - slot_start=1 next cycle; frame_done=0 (the first slot after IDLE never reports a wrap).
- ACTIVE:
  - y is a combinational function of k, sel and state; zero latency from k to y.
  - Each edge with hold=0 and cnt>0: cnt decrements by 1.
  - With hold=1: cnt holds, sel holds.
- Slot boundary (ACTIVE, cnt==0, hold=0):
  - If en=1 and mask!=0: the next lane is the first enabled lane strictly after sel, with wrap.
    - Load sel=next, cnt=DWELL-1, slot_start=1.
    - frame_done=1 if next<=old sel.
    - A single enabled lane reselects itself, giving frame_done on every slot.
  - Else: go to IDLE, rr_ptr=(sel+1) mod 8, y=0, busy=0 next cycle.
- Slot completion:
  - A mask bit cleared for the active lane mid-slot does not shorten the slot.
  - en dropping mid-slot does not shorten the slot; the slot completes, then IDLE.
- DWELL=1: every ACTIVE cycle is a slot boundary. slot_start stays high continuously while en=1 and hold=0.
- hold and a slot boundary together: hold wins; the boundary is deferred.
- rst_n asserted mid-slot: immediate return to reset values. The next start searches from lane 0.
- All registered outputs change only on clk rising edge, except during asynchronous reset.

Decomposition:
- Shared package:
  - state encoding constants ST_IDLE=1'b0, ST_ACTIVE=1'b1.
  - NUM_LANES=8 and SEL_W=3.
- Sub-module rr_next8 (combinational):
  - Inputs mask[7:0], base[2:0], incl (1 = search includes base).
  - Outputs nxt[2:0] and found.
  - Instantiated once.
- demx1_8 is instantiated for y, with its enable input driven by k & busy.
- Target roughly 150-200 lines of RTL total.

Test Plan:
- Basic rotation:
  - Stimulus: reset, then mask=8'hFF, en=1, k=1, DWELL=4.
  - Required: sel steps 0,1,...,7,0 every 4 cycles; y=one-hot(sel); slot_start every 4th cycle; frame_done only on the 7->0 transition.
- Skipping:
  - Stimulus: mask=8'b1010_0100, en=1.
  - Required: sel sequence 2,5,7,2; frame_done when sel becomes 2 after 7.
- Single lane:
  - Stimulus: mask=8'h08.
  - Required: sel stays 3; slot_start and frame_done pulse together every DWELL cycles.
- Hold:
  - Stimulus: assert hold for 3 cycles mid-slot on lane 1.
  - Required: slot lasts DWELL+3 cycles; y[1] tracks k throughout.
- Graceful stop and resume:
  - Stimulus: drop en during lane 4's second cycle.
  - Required: lane 4 slot completes; IDLE with y=0, busy=0. On re-enable with mask=FF, first lane is 5 with frame_done=0.
- Async reset mid-slot:
  - Stimulus: pull rst_n low between edges while sel=6.
  - Required: sel, busy and y go to 0 immediately without a clock edge. After release with en=1, the first slot is lane 0.
